cntr_reg_8bit: RTL and testbench
================================

Name: cntr_reg_8bit

Overview:
Loadable down-counter with a shadow reload register and a terminal-count flag. `load` captures a start value into both the shadow register and the counter. The counter then decrements once per clock, stops at zero and flags terminal count. `re_load` restarts the count from the last loaded value without a new `data_in`. It is used as a programmable interval/timeout timer inside a single clock domain.

Parameters:
- WIDTH, 8, bit width of `data_in`, `data_out`, shadow register and counter. The 8-bit configuration is the required one; other widths must follow the same rules.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset, synchronous, active-low: sampled on rising `clk`, asserted when 0.
- load  input  1  capture `data_in` into shadow register and counter.
- re_load  input  1  copy shadow register into counter.
- data_in  input  WIDTH  start value, sampled only when `load`=1.
- data_out  output  WIDTH  current counter value, registered.
- tc  output  1  terminal count: 1 when `data_out`==0.

Behaviour:
- All state updates on the rising `clk` edge. Per-edge priority, highest first:
  1. `rst`=0: counter <= 0, shadow <= 0.
  2. `load`=1: counter <= `data_in`, shadow <= `data_in`.
  3. `re_load`=1: counter <= shadow; shadow unchanged.
  4. counter != 0: counter <= counter - 1.
  5. counter == 0: counter holds 0. No wrap to all-ones.
- Reset values: `data_out`=0, shadow=0, `tc`=1.
- `tc` is combinational from the counter register: `tc` = (counter == 0). No extra latency relative to `data_out`.
- Latency:
  - After `load` with value N at edge k, `data_out`=N after edge k, then N-1 after k+1, and so on.
  - `data_out` reaches 0 after edge k+N; `tc` rises at the same time.
- `load` and `re_load` both high: `load` wins, shadow and counter take `data_in`.
- `load` with `data_in`=0: counter=0, `tc`=1 immediately after the edge.
- `re_load` with shadow=0, including after reset: counter=0, `tc` stays 1.
- `re_load` mid-count: counter restarts at the shadow value; the next edge decrements it.
- Holding `load` or `re_load` high for several cycles: counter holds the reloaded value, no decrement, until the signal drops.
- Reset mid-count: counter and shadow clear on that edge. A later `re_load` restarts from 0, not from the pre-reset value.
- `data_in` is ignored whenever `load`=0.
- No X propagation from `data_in` when `load`=0.

Decomposition:
- Shared package `cntr_reg_pkg`:
  - localparam `CNTR_WIDTH_DEFAULT`=8.
  - typedef `cntr_val_t` = logic [WIDTH-1:0].
- One natural sub-module, `cntr_shadow_reg`: WIDTH-bit register with synchronous active-low clear and load enable, holding the reload value.
- Counter next-state and `tc` logic stay in the top module.

Test Plan:
- Reset then idle: hold `rst`=0 for 2 edges, release, keep `load`/`re_load` low for 5 cycles -> `data_out`=0, `tc`=1 throughout.
- Load and count: `data_in`=0x0F, `load` for 1 cycle -> `data_out` sequence 15,14,…,1,0 on successive edges. `tc`=0 while nonzero, `tc`=1 when 0, and the counter stays at 0 for at least 5 further cycles.
- Reload: after the count from 0x0F expires, pulse `re_load` 1 cycle -> `data_out`=15 on the next edge, `tc`=0, then counts down again.
- Reload mid-count plus priority:
  - Load 0xFF, wait 3 cycles (`data_out`=0xFC), pulse `re_load` -> `data_out`=0xFF.
  - Assert `load` with `data_in`=0x05 and `re_load` together -> `data_out`=5, shadow=5.
- Reset mid-operation: load 0xFF, after 20 cycles drive `rst`=0 for 1 edge -> `data_out`=0, `tc`=1. Then pulse `re_load` -> `data_out` stays 0.
- Zero load: `load` with `data_in`=0x00 -> `data_out`=0, `tc`=1 after that edge, no wrap to 0xFF on later edges.

Source files
------------

// File: rtl/cntr_reg_pkg.sv
// Shared definitions for the loadable down-counter and its shadow reload register.
package cntr_reg_pkg;

    localparam int CNTR_WIDTH_DEFAULT = 8;

    typedef logic [CNTR_WIDTH_DEFAULT-1:0] cntr_val_t;

endpackage

// File: rtl/cntr_shadow_reg.sv
// Holds the last loaded start value so the counter can be restarted without new data.
module cntr_shadow_reg
    import cntr_reg_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cntr_reg_8bit.sv
// Loadable down-counter that saturates at zero, with shadow reload and terminal-count flag.
module cntr_reg_8bit
    import cntr_reg_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             re_load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] shadow;

    cntr_shadow_reg #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .clk(clk),
        .rst(rst),
        .en (load),
        .d  (data_in),
        .q  (shadow)
    );

    // data_in is only selected under load, so its value never leaks otherwise.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = data_in;
        end else if (re_load) begin
            cnt_next = shadow;
        end else if (cnt != '0) begin
            cnt_next = cnt - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign data_out = cnt;
    assign tc       = (cnt == '0);

endmodule

// File: tb/tb_cntr_reg_8bit.sv
// Directed bench: the driver pushes hand-computed counter values; a monitor pops and compares each cycle.
module tb_cntr_reg_8bit;
    import cntr_reg_pkg::*;

    logic      clk;
    logic      rst;
    logic      load;
    logic      re_load;
    cntr_val_t data_in;
    cntr_val_t data_out;
    logic      tc;

    int checks   = 0;
    int failures = 0;

    // Each entry is {tc, data_out} expected one edge after the stimulus that pushed it.
    logic [8:0] exp_q[$];

    cntr_reg_8bit #(
        .WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .re_load (re_load),
        .data_in (data_in),
        .data_out(data_out),
        .tc      (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic ld, input logic rl,
                        input logic [7:0] din, input logic [7:0] exp_val);
        @(negedge clk);
        rst     = r;
        load    = ld;
        re_load = rl;
        data_in = din;
        exp_q.push_back({(exp_val == 8'h00), exp_val});
        @(posedge clk);
    endtask

    task automatic idle(input logic [7:0] exp_val);
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        step(1'b1, 1'b0, 1'b0, junk, exp_val);
    endtask

    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({tc, data_out} !== e) begin
                    failures++;
                    $display("FAIL cycle_check t=%0t: got tc=%0b data_out=0x%02h, want tc=%0b data_out=0x%02h",
                             $time, tc, data_out, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin : driver
        rst     = 1'b0;
        load    = 1'b0;
        re_load = 1'b0;
        data_in = 8'h00;

        // Reset for two edges, then idle with random ignored data_in.
        step(1'b0, 1'b0, 1'b0, 8'hAA, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h55, 8'h00);
        for (int i = 0; i < 5; i++) idle(8'h00);

        // re_load right after reset: shadow is zero.
        step(1'b1, 1'b0, 1'b1, 8'h77, 8'h00);

        // Load 0x0F and count to zero, then saturate.
        step(1'b1, 1'b1, 1'b0, 8'h0F, 8'h0F);
        for (int i = 14; i >= 0; i--) idle(8'(i));
        for (int i = 0; i < 5; i++) idle(8'h00);

        // Reload after expiry.
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'h0F);
        idle(8'h0E);
        idle(8'h0D);
        idle(8'h0C);

        // Reload mid-count from 0xFF.
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
        idle(8'hFE);
        idle(8'hFD);
        idle(8'hFC);
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF);
        idle(8'hFE);

        // load beats re_load; shadow becomes 5.
        step(1'b1, 1'b1, 1'b1, 8'h05, 8'h05);
        idle(8'h04);
        idle(8'h03);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'hC3, 8'h05);
        idle(8'h04);

        // Held load keeps the value without decrementing.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h07, 8'h07);
        idle(8'h06);

        // Reset mid-count clears shadow too.
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
        for (int i = 1; i <= 20; i++) idle(8'(8'hFF - i));
        step(1'b0, 1'b0, 1'b0, 8'h99, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h99, 8'h00);
        idle(8'h00);

        // Zero load: terminal count immediately, no wrap.
        step(1'b1, 1'b1, 1'b0, 8'h21, 8'h21);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) idle(8'h00);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
